raise_freq: RTL and testbench
=============================

Name: raise_freq

Overview:
- Frequency-domain pitch-raise stage between the two-channel FFT front end and the IFFT back end.
- Captures one 64-bin spectrum frame from each of two FFT streams into ping-pong buffers.
- Emits one combined spectrum in which every bin is moved up by SHIFT bins: output bin k comes from input bin k−SHIFT, and bins below SHIFT are zero.
- The combined value is the per-component average of the two channels.

Parameters:
- N_BINS, 64: bins per frame; freq index width = log2(N_BINS) = 6.
- SHIFT, 4: upward bin shift, 0 ≤ SHIFT < N_BINS.
- DATA_W, 32: bin word width, {re[31:16], im[15:0]}, both two's-complement.

Ports:
- clk, in, 1: single system clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- fft1_data, in, 32: channel-1 bin value {re, im}.
- fft1_valid, in, 1: channel-1 data/freq valid this cycle.
- freq1, in, 6: bin index of fft1_data.
- fft1_fin, in, 1: channel-1 FFT has finished computing and is streaming results; qualifies valid.
- fft2_data, in, 32: channel-2 bin value.
- fft2_valid, in, 1: channel-2 valid.
- freq2, in, 6: channel-2 bin index.
- fft2_fin, in, 1: channel-2 streaming qualifier.
- raise_valid, out, 1: raise_data/freq_out valid.
- raise_fin, out, 1: one-cycle pulse on the last output bin of a frame.
- raise_data, out, 32: shifted, averaged bin {re, im}.
- freq_out, out, 6: output bin index.

Behaviour:
- Reset (async, rst=1): raise_valid=0, raise_fin=0, raise_data=0, freq_out=0. Capture flags, bank pointers and output counter clear; buffer contents are zeroed. Reset mid-frame or mid-output discards everything; nothing is emitted after release until a new full frame is captured.
- Capture: a channel-n sample is accepted when fftn_valid && fftn_fin. The accepted sample writes fftn_data into the channel-n write bank at address freqn; freq and data belong to the same cycle.
  - Any bin order is allowed. Rewriting a bin overwrites it.
  - The two channels are independent and need not be cycle-aligned.
- Frame complete: occurs when both channels have accepted bin N_BINS−1 into the current write bank. On that edge:
  - the write bank swaps (ping-pong), and the completed bank becomes the read bank;
  - a channel that has already completed accepts nothing further until the swap.
- Output: starts the cycle after frame completion, at a latency of 1 clk after the later last-bin capture.
  - One bin per cycle for N_BINS consecutive cycles: freq_out = k for k = 0..63, raise_valid=1.
  - For k < SHIFT: raise_data = 0.
  - For k ≥ SHIFT, with a = ch1[k−SHIFT] and b = ch2[k−SHIFT]:
    - re_out = (sext17(a.re) + sext17(b.re)) >>> 1, truncated to 16 bits;
    - im_out is computed the same way;
    - the arithmetic shift floors toward −inf; no overflow is possible.
  - raise_fin=1 only on the cycle where freq_out=63.
  - When not streaming: raise_valid=0, raise_fin=0, and raise_data/freq_out hold their last value.
- Back-to-back frames:
  - Capture of the next frame proceeds in the other bank while output streams.
  - If a frame completes while output is still streaming, the new output starts the cycle after the current last bin, with no gap.
  - If a completion arrives while both banks are occupied (write bank full, read bank still streaming), the new frame is dropped and its flags clear.
- Simultaneous accept-and-swap: an accepted sample on the swap edge writes into the new write bank.

Decomposition:
- Package raise_freq_pkg:
  - N_BINS, FREQ_W=6, DATA_W, HALF_W=16;
  - a bin_t struct {re, im};
  - a function for the averaging arithmetic.
- One sub-module, raise_freq_bank: dual 64×32 ping-pong storage with a write port and a read port, instantiated once per channel.
- The top level holds the capture flags, the swap control, the output counter/FSM (IDLE, STREAM) and the shift/average datapath.

Test Plan:
- Reset: assert rst mid-stream at arbitrary times -> all outputs 0 immediately; no raise_valid until a full new frame has been captured.
- Ramp frame: both channels send bins 0..63 with fin=1 and data {k, −k} (ch1) / {k+2, −k} (ch2) -> starting one cycle after bin 63, 64 valid cycles with freq_out 0..63.
  - Bins 0..3 are 0.
  - Bin k≥4 = {k−3, −(k−4)}.
  - raise_fin pulses only at freq_out=63.
- Averaging sign/extremes: ch1 re=0x7FFF, ch2 re=0x7FFF -> 0x7FFF. re=0x8000 with 0x8000 -> 0x8000. re=0xFFFF (−1) with 0x0000 -> 0xFFFF (−1, floor).
- Channel skew and fin gating: ch2 lags ch1 by 10 cycles; some samples arrive with valid=1, fin=0 -> fin=0 samples are ignored; output starts the cycle after ch2's bin 63 is accepted.
- Continuous 512-sample stream, 1 bin/cycle on both channels -> 8 frames emitted back-to-back with no gaps and no drops; raise_fin pulses once per frame.
- Out-of-order bins with a duplicate write to bin 10 -> the last written value is used, appearing at freq_out=14.

Source files
------------

// File: rtl/raise_freq_pkg.sv
// Shared types and arithmetic for the pitch-raise spectrum stage.
// A bin is a packed {re, im} pair of signed half-words.
package raise_freq_pkg;

  localparam int N_BINS    = 64;
  localparam int FREQ_W    = $clog2(N_BINS);
  localparam int DATA_W    = 32;
  localparam int HALF_W    = DATA_W / 2;
  localparam int SHIFT_DEF = 4;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } bin_t;

  typedef enum logic {IDLE, STREAM} state_t;

  // One guard bit makes the sum exact; dropping the LSB is a floor divide by two.
  function automatic logic signed [HALF_W-1:0] avg_half(input logic signed [HALF_W-1:0] a,
                                                        input logic signed [HALF_W-1:0] b);
    logic signed [HALF_W:0] sum;
    sum = {a[HALF_W-1], a} + {b[HALF_W-1], b};
    return sum[HALF_W:1];
  endfunction

  function automatic bin_t avg_bin(input bin_t a, input bin_t b);
    bin_t r;
    r.re = avg_half(a.re, b.re);
    r.im = avg_half(a.im, b.im);
    return r;
  endfunction

endpackage

// File: rtl/raise_freq_bank.sv
// Two-bank (ping-pong) bin store for one channel: one write port, one
// asynchronous read port, contents cleared on reset.
module raise_freq_bank
  import raise_freq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [FREQ_W-1:0] waddr_i,
  input  bin_t              wdata_i,
  input  logic              rbank_i,
  input  logic [FREQ_W-1:0] raddr_i,
  output bin_t              rdata_o
);

  bin_t mem_q [2][N_BINS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_BINS; i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[wbank_i][waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rbank_i][raddr_i];

endmodule

// File: rtl/raise_freq.sv
// Pitch-raise stage: captures a frame per FFT channel, then streams the
// two-channel average with every bin moved up by SHIFT.
module raise_freq
  import raise_freq_pkg::*;
#(
  parameter int unsigned SHIFT = SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fft1_data,
  input  logic              fft1_valid,
  input  logic [FREQ_W-1:0] freq1,
  input  logic              fft1_fin,
  input  logic [DATA_W-1:0] fft2_data,
  input  logic              fft2_valid,
  input  logic [FREQ_W-1:0] freq2,
  input  logic              fft2_fin,
  output logic              raise_valid,
  output logic              raise_fin,
  output logic [DATA_W-1:0] raise_data,
  output logic [FREQ_W-1:0] freq_out
);

  localparam logic [FREQ_W-1:0] LAST    = FREQ_W'(N_BINS - 1);
  localparam logic [FREQ_W-1:0] SHIFT_F = FREQ_W'(SHIFT);

  state_t            state_q, state_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic              done1_q, done1_d, done2_q, done2_d;
  logic [FREQ_W-1:0] cnt_q, cnt_d;
  logic              vld_q, vld_d, fin_q, fin_d;
  bin_t              data_q, data_d;
  logic [FREQ_W-1:0] freq_q, freq_d;

  logic              pending, can_start, go;
  logic              acc1, acc2, last1, last2, wbank;
  logic              emit, rbank;
  logic [FREQ_W-1:0] k_cur, raddr;
  bin_t              rd1, rd2;

  raise_freq_bank u_bank1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (acc1),
    .wbank_i(wbank),
    .waddr_i(freq1),
    .wdata_i(bin_t'(fft1_data)),
    .rbank_i(rbank),
    .raddr_i(raddr),
    .rdata_o(rd1)
  );

  raise_freq_bank u_bank2 (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (acc2),
    .wbank_i(wbank),
    .waddr_i(freq2),
    .wdata_i(bin_t'(fft2_data)),
    .rbank_i(rbank),
    .raddr_i(raddr),
    .rdata_o(rd2)
  );

  always_comb begin
    // A frame left waiting (both flags set) is launched only when the read bank frees up.
    pending   = done1_q && done2_q;
    can_start = (state_q == IDLE) || (cnt_q == LAST);
    acc1      = fft1_valid && fft1_fin && (!done1_q || (pending && can_start));
    acc2      = fft2_valid && fft2_fin && (!done2_q || (pending && can_start));
    last1     = acc1 && (freq1 == LAST);
    last2     = acc2 && (freq2 == LAST);
    go        = can_start && (pending || ((done1_q || last1) && (done2_q || last2)));
    wbank     = (pending && can_start) ? ~wr_bank_q : wr_bank_q;

    if (go) begin
      done1_d = pending && last1;
      done2_d = pending && last2;
    end else begin
      done1_d = done1_q || last1;
      done2_d = done2_q || last2;
    end

    emit  = (state_q == STREAM) || go;
    k_cur = (state_q == STREAM) ? cnt_q : '0;
    rbank = (state_q == STREAM) ? rd_bank_q : wr_bank_q;
    raddr = k_cur - SHIFT_F;

    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;
    if (state_q == IDLE) begin
      if (go) begin
        state_d   = STREAM;
        cnt_d     = FREQ_W'(1);
        rd_bank_d = wr_bank_q;
        wr_bank_d = ~wr_bank_q;
      end
    end else begin
      cnt_d = cnt_q + FREQ_W'(1);
      if (cnt_q == LAST) begin
        if (go) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
        end else begin
          state_d = IDLE;
        end
      end
    end

    vld_d  = emit;
    fin_d  = emit && (k_cur == LAST);
    data_d = data_q;
    freq_d = freq_q;
    if (emit) begin
      freq_d = k_cur;
      data_d = (k_cur < SHIFT_F) ? '0 : avg_bin(rd1, rd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      done1_q   <= 1'b0;
      done2_q   <= 1'b0;
      cnt_q     <= '0;
      vld_q     <= 1'b0;
      fin_q     <= 1'b0;
      data_q    <= '0;
      freq_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      done1_q   <= done1_d;
      done2_q   <= done2_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      fin_q     <= fin_d;
      data_q    <= data_d;
      freq_q    <= freq_d;
    end
  end

  assign raise_valid = vld_q;
  assign raise_fin   = fin_q;
  assign raise_data  = data_q;
  assign freq_out    = freq_q;

endmodule

// File: tb/tb_raise_freq.sv
// Directed bench for raise_freq: reset, ramp, extremes, skew/fin gating,
// out-of-order capture, continuous back-to-back frames, mid-stream reset.
module tb_raise_freq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fft1_data, fft2_data, raise_data;
  logic        fft1_valid, fft1_fin, fft2_valid, fft2_fin;
  logic [5:0]  freq1, freq2, freq_out;
  logic        raise_valid, raise_fin;
  int          checks = 0;
  int          errors = 0;

  raise_freq dut (
    .clk        (clk),
    .rst        (rst),
    .fft1_data  (fft1_data),
    .fft1_valid (fft1_valid),
    .freq1      (freq1),
    .fft1_fin   (fft1_fin),
    .fft2_data  (fft2_data),
    .fft2_valid (fft2_valid),
    .freq2      (freq2),
    .fft2_fin   (fft2_fin),
    .raise_valid(raise_valid),
    .raise_fin  (raise_fin),
    .raise_data (raise_data),
    .freq_out   (freq_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int re, input int im);
    logic [15:0] r, i;
    r = 16'(re);
    i = 16'(im);
    return {r, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    fft1_valid = 0; fft1_fin = 0; freq1 = 0; fft1_data = 0;
    fft2_valid = 0; fft2_fin = 0; freq2 = 0; fft2_data = 0;
  endtask

  task automatic drive(input int ch, input logic v, input logic f, input int bin, input logic [31:0] d);
    if (ch == 1) begin
      fft1_valid = v; fft1_fin = f; freq1 = 6'(bin); fft1_data = d;
    end else begin
      fft2_valid = v; fft2_fin = f; freq2 = 6'(bin); fft2_data = d;
    end
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1;
    #1;
    checks++;
    if ({raise_valid, raise_fin, raise_data, freq_out} !== 40'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b f=%b d=%h q=%0d exp all 0", raise_valid, raise_fin, raise_data, freq_out);
    end
    tick(); tick();
    rst = 0;
    tick();
    checks++;
    if (raise_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got v=%b exp 0", raise_valid);
    end
  endtask

  task automatic test_ramp();
    logic [31:0] e;
    for (int k = 0; k < 64; k++) begin
      drive(1, 1, 1, k, mk(k, -k));
      drive(2, 1, 1, k, mk(k + 2, -k));
      if (k == 63) begin
        checks++;
        if (raise_valid !== 1'b0) begin
          errors++;
          $display("FAIL ramp_early got v=%b exp 0", raise_valid);
        end
      end
      tick();
    end
    idle_in();
    for (int k = 0; k < 64; k++) begin
      e = (k < 4) ? 32'h0 : mk(k - 3, -(k - 4));
      checks++;
      if (raise_valid !== 1'b1 || freq_out !== 6'(k) || raise_data !== e || raise_fin !== (k == 63)) begin
        errors++;
        $display("FAIL ramp k=%0d got v=%b q=%0d d=%h fin=%b exp d=%h", k, raise_valid, freq_out, raise_data, raise_fin, e);
      end
      tick();
    end
    checks++;
    if (raise_valid !== 1'b0 || raise_fin !== 1'b0 || raise_data !== mk(60, -59) || freq_out !== 6'd63) begin
      errors++;
      $display("FAIL ramp_hold got v=%b fin=%b d=%h q=%0d exp v=0 d=%h q=63", raise_valid, raise_fin, raise_data, freq_out, mk(60, -59));
    end
  endtask

  task automatic test_extremes();
    logic [31:0] d1 [64];
    logic [31:0] d2 [64];
    logic [31:0] ex [64];
    for (int k = 0; k < 64; k++) begin
      d1[k] = 0; d2[k] = 0; ex[k] = 0;
    end
    d1[0] = 32'h7FFF_8000; d2[0] = 32'h7FFF_8000; ex[4] = 32'h7FFF_8000;
    d1[1] = 32'hFFFF_0001; d2[1] = 32'h0000_0000; ex[5] = 32'hFFFF_0000;
    d1[2] = 32'h8000_0003; d2[2] = 32'h7FFF_0002; ex[6] = 32'hFFFF_0002;
    for (int k = 0; k < 64; k++) begin
      drive(1, 1, 1, k, d1[k]);
      drive(2, 1, 1, k, d2[k]);
      tick();
    end
    idle_in();
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (raise_valid !== 1'b1 || freq_out !== 6'(k) || raise_data !== ex[k] || raise_fin !== (k == 63)) begin
        errors++;
        $display("FAIL extremes k=%0d got v=%b q=%0d d=%h fin=%b exp d=%h", k, raise_valid, freq_out, raise_data, raise_fin, ex[k]);
      end
      tick();
    end
  endtask

  task automatic test_skew_fin();
    logic [31:0] e;
    for (int c = 0; c < 74; c++) begin
      if (c < 64) drive(1, 1, 1, c, mk(c, 0));
      else        drive(1, 1, 1, 20, 32'hBAD0_BAD0);
      if (c < 10) drive(2, 1, 0, 63, 32'hDEAD_BEEF);
      else        drive(2, 1, 1, c - 10, mk(c - 10, 2 * (c - 10)));
      checks++;
      if (raise_valid !== 1'b0) begin
        errors++;
        $display("FAIL skew_early c=%0d got v=%b exp 0", c, raise_valid);
      end
      tick();
    end
    idle_in();
    for (int k = 0; k < 64; k++) begin
      e = (k < 4) ? 32'h0 : mk(k - 4, k - 4);
      checks++;
      if (raise_valid !== 1'b1 || freq_out !== 6'(k) || raise_data !== e || raise_fin !== (k == 63)) begin
        errors++;
        $display("FAIL skew k=%0d got v=%b q=%0d d=%h fin=%b exp d=%h", k, raise_valid, freq_out, raise_data, raise_fin, e);
      end
      tick();
    end
  endtask

  task automatic test_out_of_order();
    logic [31:0] e;
    int b;
    drive(1, 1, 1, 10, mk(16'h1234, 16'h5678));
    drive(2, 1, 1, 10, mk(16'h4321, 16'h0876));
    tick();
    for (int i = 0; i < 63; i++) begin
      b = (i * 5) % 63;
      drive(1, 1, 1, b, mk(b, 100));
      drive(2, 1, 1, b, mk(b, 100));
      tick();
    end
    drive(1, 1, 1, 63, mk(63, 100));
    drive(2, 1, 1, 63, mk(63, 100));
    tick();
    idle_in();
    for (int k = 0; k < 64; k++) begin
      e = (k < 4) ? 32'h0 : mk(k - 4, 100);
      checks++;
      if (raise_valid !== 1'b1 || freq_out !== 6'(k) || raise_data !== e || raise_fin !== (k == 63)) begin
        errors++;
        $display("FAIL ooo k=%0d got v=%b q=%0d d=%h fin=%b exp d=%h", k, raise_valid, freq_out, raise_data, raise_fin, e);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int f, k, o, fins;
    fins = 0;
    for (int c = 0; c < 576; c++) begin
      if (c < 512) begin
        f = c / 64; k = c % 64;
        drive(1, 1, 1, k, mk(k + f, f));
        drive(2, 1, 1, k, mk(k + f, -f - 1));
      end else begin
        idle_in();
      end
      tick();
      o = c - 63;
      checks++;
      if (o < 0 || o >= 512) begin
        if (raise_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle c=%0d got v=%b exp 0", c, raise_valid);
        end
      end else begin
        f = o / 64; k = o % 64;
        e = (k < 4) ? 32'h0 : mk(k - 4 + f, -1);
        if (raise_fin === 1'b1) fins++;
        if (raise_valid !== 1'b1 || freq_out !== 6'(k) || raise_data !== e || raise_fin !== (k == 63)) begin
          errors++;
          $display("FAIL b2b o=%0d got v=%b q=%0d d=%h fin=%b exp q=%0d d=%h", o, raise_valid, freq_out, raise_data, raise_fin, k, e);
        end
      end
    end
    checks++;
    if (fins != 8) begin
      errors++;
      $display("FAIL b2b_fin_count got %0d exp 8", fins);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 64; k++) begin
      drive(1, 1, 1, k, mk(k + 9, k));
      drive(2, 1, 1, k, mk(k + 9, k));
      tick();
    end
    idle_in();
    repeat (10) tick();
    rst = 1;
    #1;
    checks++;
    if ({raise_valid, raise_fin, raise_data, freq_out} !== 40'h0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b f=%b d=%h q=%0d exp all 0", raise_valid, raise_fin, raise_data, freq_out);
    end
    tick(); tick();
    rst = 0;
    for (int k = 0; k < 32; k++) begin
      drive(1, 1, 1, k, mk(7, 7));
      drive(2, 1, 1, k, mk(7, 7));
      tick();
    end
    idle_in();
    for (int c = 0; c < 80; c++) begin
      checks++;
      if (raise_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet c=%0d got v=%b exp 0", c, raise_valid);
      end
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    tick();
    drive(1, 1, 1, 63, mk(1, 1));
    drive(2, 1, 1, 63, mk(1, 1));
    tick();
    idle_in();
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (raise_valid !== 1'b1 || freq_out !== 6'(k) || raise_data !== 32'h0 || raise_fin !== (k == 63)) begin
        errors++;
        $display("FAIL zeroed k=%0d got v=%b q=%0d d=%h fin=%b exp d=0", k, raise_valid, freq_out, raise_data, raise_fin);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    tick();
    test_extremes();
    tick();
    test_skew_fin();
    tick();
    test_out_of_order();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
